fifo16_ram_ctl: RTL and testbench

- Control and staging stage that sits directly upstream of a bank of W single-port 16x1 synchronous-write distributed RAMs. Bit i of the bank is one RAM16X1S.
- Turns a valid/ready push stream into the bank's shared address, write-enable and data inputs. Consumes the bank's asynchronous read output to present a registered head word downstream.
- Total capacity is 17 words: 16 in RAM plus 1 head register.
- Used as the standard buffering block in front of the UART TX and other byte streams in the SoC.

---
 rtl/fifo16_pkg.sv | 7 +
 rtl/fifo16_ram_ctl.sv | 76 +++++++
 tb/tb_fifo16_ram_ctl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fifo16_pkg.sv
// Shared sizing constants for the 16-deep distributed-RAM FIFO controller.
package fifo16_pkg;
  localparam int DEPTH_RAM = 16;
  localparam int PTR_W     = 4;
  localparam int LVL_W     = 5;
  localparam int CAP       = 17;
endpackage

// File: rtl/fifo16_ram_ctl.sv
// Push-stream controller for a bank of W RAM16X1S cells plus one registered head word.
module fifo16_ram_ctl
  import fifo16_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic [PTR_W-1:0] ram_a,
  output logic             ram_we,
  output logic [W-1:0]     ram_d,
  input  logic [W-1:0]     ram_o,
  output logic [LVL_W-1:0] level
);

  localparam logic [LVL_W-1:0] SC_FULL = LVL_W'(DEPTH_RAM);

  logic [PTR_W-1:0] wptr, rptr;
  logic [LVL_W-1:0] sc;
  logic             hv;
  logic [W-1:0]     head;

  logic pop, refill, push, bypass, wr, full_stall;

  always_comb begin
    pop        = hv && out_ready;
    refill     = pop && (sc != '0);
    full_stall = (sc == SC_FULL) && hv && !pop;
    // The single RAM port is busy reading during a refill, so pushes stall.
    in_ready   = !rst && !refill && !full_stall;
    push       = in_valid && in_ready;
    bypass     = push && (sc == '0) && (!hv || pop);
    wr         = push && !bypass;
  end

  assign ram_we    = wr && !rst;
  assign ram_a     = wr ? wptr : rptr;
  assign ram_d     = in_data;
  assign out_valid = hv;
  assign out_data  = head;
  assign level     = sc + LVL_W'(hv);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      sc   <= '0;
      hv   <= 1'b0;
      head <= '0;
    end else begin
      if (refill) begin
        head <= ram_o;
        rptr <= rptr + 1'b1;
      end else if (bypass) begin
        head <= in_data;
        hv   <= 1'b1;
      end else if (pop) begin
        hv <= 1'b0;
      end

      if (wr) begin
        wptr <= wptr + 1'b1;
        sc   <= sc + 1'b1;
      end else if (refill) begin
        sc <= sc - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo16_ram_ctl.sv
// Bench for fifo16_ram_ctl with a behavioural 16xW RAM bank and a queue reference model.
module tb_fifo16_ram_ctl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [3:0]   ram_a;
  logic         ram_we;
  logic [W-1:0] ram_d;
  logic [W-1:0] ram_o;
  logic [4:0]   level;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo16_ram_ctl #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .ram_a(ram_a), .ram_we(ram_we), .ram_d(ram_d), .ram_o(ram_o),
    .level(level)
  );

  // RAM16X1S bank: synchronous write, asynchronous read.
  logic [W-1:0] ram [16];
  initial for (int i = 0; i < 16; i++) ram[i] = 8'hEE;
  always @(posedge clk) if (ram_we) ram[ram_a] <= ram_d;
  assign ram_o = ram[ram_a];

  // Head-valid must be set whenever the RAM holds data.
  always @(negedge clk) begin
    if (rst === 1'b0)
      assert (dut.hv || dut.sc == 0) else begin
        n_bad++;
        $display("FAIL invariant hv=%0b sc=%0d (required sc=0 when hv=0)", dut.hv, dut.sc);
      end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
    end
  endtask

  task automatic apply(input bit r, input bit v, input logic [W-1:0] d, input bit ordy);
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in_data = d; out_ready = ordy;
    @(negedge clk);
  endtask

  // Reference model: ordered word list, plus counts of RAM writes/reads since reset.
  logic [W-1:0] q[$];
  int wcnt = 0;
  int rcnt = 0;

  task automatic mstep(input bit r, input bit v, input logic [W-1:0] d, input bit ordy);
    int  sz;
    bit  e_ir, push, pop, byp, e_we, refill;
    apply(r, v, d, ordy);
    sz     = q.size();
    e_ir   = !r && sz < 17 && !(ordy && sz >= 2);
    push   = v && e_ir;
    pop    = ordy && sz >= 1;
    byp    = push && (sz == 0 || (sz == 1 && ordy));
    e_we   = push && !byp;
    refill = pop && sz >= 2;
    chk("in_ready", int'(in_ready), int'(e_ir));
    chk("ram_we", int'(ram_we), int'(e_we));
    chk("out_valid", int'(out_valid), int'(sz > 0));
    chk("level", int'(level), sz);
    if (sz > 0) chk("out_data", int'(out_data), int'(q[0]));
    if (e_we) chk("ram_a_wr", int'(ram_a), wcnt % 16);
    if (refill) chk("ram_a_rd", int'(ram_a), rcnt % 16);
    if (r) begin
      q.delete(); wcnt = 0; rcnt = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
      if (e_we) wcnt++;
      if (refill) rcnt++;
    end
  endtask

  typedef struct {
    bit           r, v, ordy;
    logic [W-1:0] d;
    bit           e_ir, e_ov, e_we, od_chk;
    logic [W-1:0] e_od;
    int           e_lvl;
  } vec_t;

  vec_t tbl[8];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    //         r  v  ordy d      ir ov we odc od     lvl
    tbl[0] = '{1, 0, 0, 8'h00, 0, 0, 0, 1, 8'h00, 0};
    tbl[1] = '{0, 1, 0, 8'hA5, 1, 0, 0, 1, 8'h00, 0};
    tbl[2] = '{0, 0, 0, 8'h00, 1, 1, 0, 1, 8'hA5, 1};
    tbl[3] = '{0, 1, 0, 8'h5A, 1, 1, 1, 1, 8'hA5, 1};
    tbl[4] = '{0, 0, 1, 8'h00, 0, 1, 0, 1, 8'hA5, 2};
    tbl[5] = '{0, 0, 1, 8'h00, 1, 1, 0, 1, 8'h5A, 1};
    tbl[6] = '{0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
    tbl[7] = '{1, 1, 0, 8'h33, 0, 0, 0, 0, 8'h00, 0};

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].ordy);
      chk($sformatf("tbl%0d_in_ready", i), int'(in_ready), int'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_out_valid", i), int'(out_valid), int'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_ram_we", i), int'(ram_we), int'(tbl[i].e_we));
      chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].e_lvl);
      if (tbl[i].od_chk) chk($sformatf("tbl%0d_out_data", i), int'(out_data), int'(tbl[i].e_od));
    end

    // Fill to 17, refuse an 18th, drain in order.
    mstep(1, 0, 0, 0); mstep(1, 0, 0, 0);
    for (int i = 0; i < 17; i++) mstep(0, 1, 8'(i), 0);
    mstep(0, 1, 8'h77, 0);
    for (int i = 0; i < 19; i++) mstep(0, 0, 0, 1);

    // Full with simultaneous push and pop: refill first, push next cycle.
    for (int i = 0; i < 17; i++) mstep(0, 1, 8'(8'h80 + i), 0);
    mstep(0, 1, 8'h40, 1);
    mstep(0, 1, 8'h40, 0);
    mstep(0, 0, 0, 0);
    chk("full_again_level", int'(level), 17);
    for (int i = 0; i < 19; i++) mstep(0, 0, 0, 1);

    // Streaming from empty stays on the bypass path.
    mstep(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) mstep(0, 1, 8'(8'hC0 + i), 1);
    mstep(0, 0, 0, 1);

    // Pointer wrap past 15.
    mstep(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) mstep(0, 1, 8'(8'h10 + i), 0);
    for (int i = 0; i < 8; i++)  mstep(0, 0, 0, 1);
    for (int i = 0; i < 12; i++) mstep(0, 1, 8'(8'h30 + i), 0);
    for (int i = 0; i < 16; i++) mstep(0, 0, 0, 1);

    // Mid-stream reset leaves no stale data.
    mstep(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) mstep(0, 1, 8'(8'h60 + i), 0);
    mstep(1, 1, 8'h99, 1);
    mstep(0, 1, 8'h3C, 0);
    mstep(0, 0, 0, 0);
    chk("post_rst_head", int'(out_data), 8'h3C);
    for (int i = 0; i < 4; i++) mstep(0, 0, 0, 1);

    // Randomized traffic with phases biased toward filling and draining.
    for (int blk = 0; blk < 12; blk++) begin
      int pv = (blk % 3 == 0) ? 9 : 5;
      int pr = (blk % 3 == 0) ? 2 : ((blk % 3 == 1) ? 9 : 5);
      for (int c = 0; c < 150; c++) begin
        bit r = ($urandom_range(0, 299) == 0);
        mstep(r, $urandom_range(0, 9) < pv, 8'($urandom), $urandom_range(0, 9) < pr);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
